// File: rtl/pc_branch_unit.sv
// ---------------------------------------------------------------------------
// pc_branch_unit
// Program-counter register and next-PC sequencer for the MIPS fetch stage.
// Forms PC+4, branch, J/JAL and JR targets, and enforces the single
// branch-delay slot: an accepted redirect first fetches pc+4 (the delay
// slot), then the stored target on the following edge.
// ---------------------------------------------------------------------------
module pc_branch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned WIDTH    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             stall,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_offset,
    input  logic             jump,
    input  logic [25:0]      jump_index,
    input  logic             jr,
    input  logic [WIDTH-1:0] jr_addr,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic             in_delay_slot,
    output logic             addr_error
);

    typedef enum logic {
        SEQ   = 1'b0,
        DELAY = 1'b1
    } state_t;

    state_t           r_state;
    state_t           w_next_state;
    logic [WIDTH-1:0] r_pc;
    logic [WIDTH-1:0] r_pending_target;
    logic             r_addr_error;

    logic [WIDTH-1:0] w_pc_plus4;
    logic [WIDTH-1:0] w_branch_target;
    logic [WIDTH-1:0] w_jump_target;
    logic [WIDTH-1:0] w_jr_target;
    logic [WIDTH-1:0] w_sel_target;
    logic [WIDTH-1:0] w_next_pc;
    logic             w_redirect;
    logic             w_accept;
    logic             w_jr_misaligned;

    // Target arithmetic is modulo 2^32; wrap-around is intentional.
    assign w_pc_plus4      = r_pc + 32'd4;
    assign w_branch_target = w_pc_plus4 + branch_offset;
    assign w_jump_target   = {w_pc_plus4[WIDTH-1:WIDTH-4], jump_index, 2'b00};
    // A misaligned JR still redirects, to the word containing jr_addr.
    assign w_jr_target     = {jr_addr[WIDTH-1:2], 2'b00};
    assign w_redirect      = jr | jump | branch_taken;
    assign w_jr_misaligned = (jr_addr[1:0] != 2'b00);

    // Redirect source priority: jr over jump over branch_taken.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        w_sel_target = w_branch_target;
        if (jr) begin
            w_sel_target = w_jr_target;
        end else if (jump) begin
            w_sel_target = w_jump_target;
        end
    end

    // Sequencer state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its peers.
            r_state <= SEQ;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Sequencer next state: a redirect in SEQ opens the delay slot; DELAY always
    // returns to SEQ; a stall freezes the sequencer.
    always_comb begin
        w_next_state = r_state;
        if (!stall) begin
            case (r_state)
                SEQ:     if (w_redirect) w_next_state = DELAY;
                DELAY:   w_next_state = SEQ;
                default: w_next_state = SEQ;
            endcase
        end
    end

    // Sequencer outputs: delay-slot flag, redirect acceptance and next fetch address.
    always_comb begin
        in_delay_slot = (r_state == DELAY);
        w_accept      = 1'b0;
        w_next_pc     = r_pc;
        if (!stall) begin
            if (r_state == DELAY) begin
                w_next_pc = r_pending_target;
            end else begin
                w_accept  = w_redirect;
                w_next_pc = w_pc_plus4;
            end
        end
    end

    // PC, pending target and sticky JR alignment error.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pc             <= RESET_PC;
            r_pending_target <= '0;
            r_addr_error     <= 1'b0;
        end else begin
            r_pc <= w_next_pc;
            if (w_accept) begin
                r_pending_target <= w_sel_target;
            end
            if (w_accept && jr && w_jr_misaligned) begin
                r_addr_error <= 1'b1;
            end
        end
    end

    assign pc         = r_pc;
    assign pc_plus4   = w_pc_plus4;
    assign addr_error = r_addr_error;

endmodule

// File: tb/tb_pc_branch_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_branch_unit
// Directed scenarios plus randomized traffic for pc_branch_unit, checked
// against a fetch-schedule model: an accepted redirect queues the two upcoming
// fetch addresses (delay slot, then target); otherwise fetch advances by 4.
// ---------------------------------------------------------------------------
module tb_pc_branch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_offset;
    logic        jump;
    logic [25:0] jump_index;
    logic        jr;
    logic [31:0] jr_addr;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic        in_delay_slot;
    logic        addr_error;

    pc_branch_unit #(.RESET_PC(RESET_PC), .WIDTH(32)) dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_offset (branch_offset),
        .jump          (jump),
        .jump_index    (jump_index),
        .jr            (jr),
        .jr_addr       (jr_addr),
        .pc            (pc),
        .pc_plus4      (pc_plus4),
        .in_delay_slot (in_delay_slot),
        .addr_error    (addr_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state.
    logic [31:0] m_pc;
    logic        m_err;
    logic [31:0] m_sched[$];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pc"},  pc, m_pc);
        check({tag, ".pc4"}, pc_plus4, m_pc + 32'd4);
        check({tag, ".ds"},  {31'b0, in_delay_slot}, {31'b0, (m_sched.size() == 1)});
        check({tag, ".err"}, {31'b0, addr_error}, {31'b0, m_err});
    endtask

    // One clock edge with the given request inputs; model advanced, DUT checked.
    task automatic step(input string tag, input logic s, input logic bt,
                        input logic [31:0] off, input logic j, input logic [25:0] idx,
                        input logic r, input logic [31:0] ra);
        logic [31:0] tgt;
        logic [31:0] seq_next;
        stall = s; branch_taken = bt; branch_offset = off;
        jump = j; jump_index = idx; jr = r; jr_addr = ra;
        if (!s) begin
            seq_next = m_pc + 32'd4;
            if (m_sched.size() == 0 && (r || j || bt)) begin
                if (r)      tgt = ra & 32'hFFFF_FFFC;
                else if (j) tgt = (seq_next & 32'hF000_0000) | ({6'b0, idx} * 32'd4);
                else        tgt = seq_next + off;
                if (r && (ra % 4 != 0)) m_err = 1'b1;
                m_sched.push_back(seq_next);
                m_sched.push_back(tgt);
            end
            if (m_sched.size() != 0) m_pc = m_sched.pop_front();
            else                     m_pc = seq_next;
        end
        @(posedge clk);
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic s);
        step(tag, s, 1'b0, 32'h0, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic branch(input string tag, input logic [31:0] off);
        step(tag, 1'b0, 1'b1, off, 1'b0, 26'h0, 1'b0, 32'h0);
    endtask

    task automatic goto(input logic [31:0] addr);
        step("goto_jr", 1'b0, 1'b0, 32'h0, 1'b0, 26'h0, 1'b1, addr);
        idle("goto_tgt", 1'b0);
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        m_sched.delete();
        m_pc  = RESET_PC;
        m_err = 1'b0;
        #1;
        check_all("rst_async");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_offset = '0;
        jump = 1'b0; jump_index = '0; jr = 1'b0; jr_addr = '0;
        m_pc = RESET_PC; m_err = 1'b0;
        @(posedge clk);
        #1;
        apply_reset();

        // 1: sequential fetch after reset.
        for (int i = 1; i <= 4; i++) begin
            idle("t1_seq", 1'b0);
            check("t1_lit", pc, 32'(i * 4));
        end

        // 2: forward branch.
        goto(32'h0000_0100);
        branch("t2_ds", 32'h0000_0040);
        check("t2_ds_lit", pc, 32'h0000_0104);
        idle("t2_tgt", 1'b0);
        check("t2_tgt_lit", pc, 32'h0000_0144);

        // 3: backward branch.
        goto(32'h0000_0200);
        branch("t3_ds", 32'hFFFF_FFF0);
        idle("t3_tgt", 1'b0);
        check("t3_tgt_lit", pc, 32'h0000_01F4);

        // 4: J/JAL region-relative target.
        goto(32'h3000_0010);
        step("t4_ds", 1'b0, 1'b0, 32'h0, 1'b1, 26'h0000100, 1'b0, 32'h0);
        check("t4_ds_lit", pc, 32'h3000_0014);
        idle("t4_tgt", 1'b0);
        check("t4_tgt_lit", pc, 32'h3000_0400);

        // 5: jr wins over branch, misaligned target sets sticky error.
        goto(32'h0000_0700);
        step("t5_ds", 1'b0, 1'b1, 32'h0000_1000, 1'b0, 26'h0, 1'b1, 32'h0000_0802);
        check("t5_ds_lit", pc, 32'h0000_0704);
        idle("t5_tgt", 1'b0);
        check("t5_tgt_lit", pc, 32'h0000_0800);
        check("t5_err_lit", {31'b0, addr_error}, 32'h1);
        idle("t5_sticky", 1'b0);

        // 6a: stall during the delay slot holds pc; redirects there are ignored.
        goto(32'h0000_0900);
        branch("t6_ds", 32'h0000_0020);
        for (int i = 0; i < 3; i++) begin
            step("t6_stall", 1'b1, 1'b1, 32'h0000_4000, 1'b0, 26'h0, 1'b1, 32'h0000_0003);
            check("t6_stall_lit", pc, 32'h0000_0904);
        end
        step("t6_ignore", 1'b0, 1'b1, 32'h0000_4000, 1'b1, 26'h3FF_FFFF, 1'b1, 32'h0000_0F03);
        check("t6_tgt_lit", pc, 32'h0000_0924);
        idle("t6_after", 1'b0);

        // 6b: reset in the delay slot discards the target.
        goto(32'h0000_0A00);
        branch("t6r_ds", 32'h0000_0100);
        apply_reset();
        check("t6r_lit", pc, RESET_PC);
        idle("t6r_seq", 1'b0);
        check("t6r_seq_lit", pc, 32'h0000_0004);

        // Wrap-around at the top of the address space.
        goto(32'hFFFF_FFF8);
        idle("wrap_fc", 1'b0);
        idle("wrap_0", 1'b0);
        check("wrap_lit", pc, 32'h0000_0000);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            logic [31:0] r0;
            logic [31:0] off;
            logic [31:0] ra;
            r0  = $urandom;
            off = ($urandom_range(0, 1) == 1) ? ($urandom & 32'hFFFF_FFFC)
                                              : (32'($signed(12'($urandom))) & 32'hFFFF_FFFC);
            ra  = $urandom;
            if (r0[9:8] != 2'b00) ra[1:0] = 2'b00;
            if (r0[15:10] == 6'd0) begin
                apply_reset();
            end else begin
                step("rnd", (r0[2:0] == 3'd0), (r0[4:3] == 2'd0), off,
                     (r0[6:5] == 2'd0), 26'($urandom), (r0[7] && r0[11]), ra);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
